// File: rtl/rf_seq_pkg.sv
// Shared constants for the register-file command sequencer: default sizes,
// command opcodes and the controller state encoding.
package rf_seq_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int NREG_DEF  = 8;
   localparam int SEL_W     = 3;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_MOVE  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_RD    = 3'd2,
      S_RESP  = 3'd3,
      S_MV_RD = 3'd4,
      S_MV_WR = 3'd5,
      S_CLR   = 3'd6
   } state_t;

endpackage

// File: rtl/rf_sequencer.sv
// Command sequencer driving an external register file with combinational reads:
// WRITE, READ (with response handshake), MOVE and an 8-cycle CLEAR sweep.
module rf_sequencer
   import rf_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREG  = NREG_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [SEL_W-1:0] cmd_dst,
   input  logic [SEL_W-1:0] cmd_src_a,
   input  logic [SEL_W-1:0] cmd_src_b,
   input  logic [WIDTH-1:0] cmd_imm,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_a,
   output logic [WIDTH-1:0] rsp_b,
   output logic [SEL_W-1:0] rf_in,
   output logic             rf_enable,
   output logic [SEL_W-1:0] rf_sel_A,
   output logic [SEL_W-1:0] rf_sel_B,
   output logic [WIDTH-1:0] rf_d,
   input  logic [WIDTH-1:0] rf_out_A,
   input  logic [WIDTH-1:0] rf_out_B,
   output logic             busy
);

   // Handshakes: a command transfers on a rising edge where cmd_valid and
   // cmd_ready are both high; a response transfers on an edge where rsp_valid
   // and rsp_ready are both high. Outputs depend on registered state only.

   localparam logic [SEL_W-1:0] LAST_REG = SEL_W'(NREG - 1);

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [SEL_W-1:0]   dst_q, dst_d;
   logic [SEL_W-1:0]   src_a_q, src_a_d;
   logic [SEL_W-1:0]   src_b_q, src_b_d;
   logic [WIDTH-1:0]   imm_q, imm_d;
   logic [WIDTH-1:0]   rsp_a_q, rsp_a_d;
   logic [WIDTH-1:0]   rsp_b_q, rsp_b_d;
   logic [WIDTH-1:0]   temp_q, temp_d;
   logic [SEL_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         dst_q   <= '0;
         src_a_q <= '0;
         src_b_q <= '0;
         imm_q   <= '0;
         rsp_a_q <= '0;
         rsp_b_q <= '0;
         temp_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dst_q   <= dst_d;
         src_a_q <= src_a_d;
         src_b_q <= src_b_d;
         imm_q   <= imm_d;
         rsp_a_q <= rsp_a_d;
         rsp_b_q <= rsp_b_d;
         temp_q  <= temp_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      dst_d     = dst_q;
      src_a_d   = src_a_q;
      src_b_d   = src_b_q;
      imm_d     = imm_q;
      rsp_a_d   = rsp_a_q;
      rsp_b_d   = rsp_b_q;
      temp_d    = temp_q;
      cnt_d     = cnt_q;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      rf_enable = 1'b0;
      rf_in     = '0;
      rf_d      = '0;
      rf_sel_A  = src_a_q;
      rf_sel_B  = src_b_q;

      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            rf_sel_A  = '0;
            rf_sel_B  = '0;
            if (cmd_valid) begin
               op_d    = cmd_op;
               dst_d   = cmd_dst;
               src_a_d = cmd_src_a;
               src_b_d = cmd_src_b;
               imm_d   = cmd_imm;
               unique case (cmd_op)
                  OP_WRITE: state_d = S_WR;
                  OP_READ:  state_d = S_RD;
                  OP_MOVE:  state_d = S_MV_RD;
                  default: begin
                     cnt_d   = '0;
                     state_d = S_CLR;
                  end
               endcase
            end
         end
         S_WR: begin
            rf_enable = 1'b1;
            rf_in     = dst_q;
            rf_d      = imm_q;
            state_d   = S_IDLE;
         end
         S_RD: begin
            rsp_a_d = rf_out_A;
            rsp_b_d = rf_out_B;
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         S_MV_RD: begin
            temp_d  = rf_out_A;
            state_d = S_MV_WR;
         end
         S_MV_WR: begin
            rf_enable = 1'b1;
            rf_in     = dst_q;
            rf_d      = temp_q;
            state_d   = S_IDLE;
         end
         S_CLR: begin
            rf_enable = 1'b1;
            rf_in     = cnt_q;
            // Counter parks on the last register rather than wrapping.
            if (cnt_q == LAST_REG) state_d = S_IDLE;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rsp_a = rsp_a_q;
   assign rsp_b = rsp_b_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer paired with an 8x16 register file; a transaction-level
// model predicts every output per cycle, plus directed scenarios with literal values.
module tb_rf_sequencer;
   import rf_seq_pkg::*;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [2:0]    cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
   logic [W-1:0]  cmd_imm = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [W-1:0]  rsp_a, rsp_b;
   logic [2:0]    rf_in, rf_sel_A, rf_sel_B;
   logic          rf_enable;
   logic [W-1:0]  rf_d, rf_out_A, rf_out_B;
   logic          busy;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;
   logic rand_rdy = 1'b0;
   int en_total = 0;

   always #5 clk = ~clk;

   rf_sequencer #(.WIDTH(W), .NREG(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
      .rf_in(rf_in), .rf_enable(rf_enable), .rf_sel_A(rf_sel_A), .rf_sel_B(rf_sel_B),
      .rf_d(rf_d), .rf_out_A(rf_out_A), .rf_out_B(rf_out_B), .busy(busy)
   );

   // Attached register file: synchronous write, combinational reads, no reset.
   logic [W-1:0] rf_mem [8] = '{default: '0};
   always @(posedge clk) if (rf_enable) rf_mem[rf_in] <= rf_d;
   assign rf_out_A = rf_mem[rf_sel_A];
   assign rf_out_B = rf_mem[rf_sel_B];

   always @(posedge clk) if (rf_enable) en_total <= en_total + 1;

   // Model: each accepted command expands into the list of cycles it must produce.
   typedef struct {
      logic         en;
      logic [2:0]   in;
      logic [W-1:0] d;
      logic [2:0]   sa, sb;
      logic         resp;
      logic [W-1:0] ra, rb;
   } step_t;

   step_t        exp_q[$];
   logic [W-1:0] mem_m [8] = '{default: '0};

   function automatic step_t mk(input logic en, input logic [2:0] in, input logic [W-1:0] d,
                                input logic [2:0] sa, input logic [2:0] sb, input logic resp,
                                input logic [W-1:0] ra, input logic [W-1:0] rb);
      step_t s;
      s.en = en; s.in = in; s.d = d; s.sa = sa; s.sb = sb;
      s.resp = resp; s.ra = ra; s.rb = rb;
      return s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
      end else if (exp_q.size() == 0) begin
         if (cmd_valid) begin
            case (cmd_op)
               OP_WRITE: exp_q.push_back(mk(1'b1, cmd_dst, cmd_imm, cmd_src_a, cmd_src_b, 1'b0, '0, '0));
               OP_READ: begin
                  exp_q.push_back(mk(1'b0, '0, '0, cmd_src_a, cmd_src_b, 1'b0, '0, '0));
                  exp_q.push_back(mk(1'b0, '0, '0, cmd_src_a, cmd_src_b, 1'b1,
                                     mem_m[cmd_src_a], mem_m[cmd_src_b]));
               end
               OP_MOVE: begin
                  exp_q.push_back(mk(1'b0, '0, '0, cmd_src_a, cmd_src_b, 1'b0, '0, '0));
                  exp_q.push_back(mk(1'b1, cmd_dst, mem_m[cmd_src_a], cmd_src_a, cmd_src_b, 1'b0, '0, '0));
               end
               default:
                  for (int i = 0; i < 8; i++)
                     exp_q.push_back(mk(1'b1, 3'(i), '0, cmd_src_a, cmd_src_b, 1'b0, '0, '0));
            endcase
         end
      end else if (exp_q[0].resp) begin
         if (rsp_ready) void'(exp_q.pop_front());
      end else begin
         if (exp_q[0].en) mem_m[exp_q[0].in] = exp_q[0].d;
         void'(exp_q.pop_front());
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         step_t e;
         logic  idle;
         idle = (exp_q.size() == 0);
         e = idle ? mk(1'b0, '0, '0, '0, '0, 1'b0, '0, '0) : exp_q[0];
         check("cmd_ready", 32'(cmd_ready), 32'(idle));
         check("busy", 32'(busy), 32'(!idle));
         check("rf_enable", 32'(rf_enable), 32'(e.en));
         check("rf_in", 32'(rf_in), 32'(e.in));
         check("rf_d", 32'(rf_d), 32'(e.d));
         check("rf_sel_A", 32'(rf_sel_A), 32'(e.sa));
         check("rf_sel_B", 32'(rf_sel_B), 32'(e.sb));
         check("rsp_valid", 32'(rsp_valid), 32'(e.resp));
         if (e.resp) begin
            check("rsp_a", 32'(rsp_a), 32'(e.ra));
            check("rsp_b", 32'(rsp_b), 32'(e.rb));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [2:0] d, input logic [2:0] a,
                         input logic [2:0] b, input logic [W-1:0] imm);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_dst = d; cmd_src_a = a; cmd_src_b = b; cmd_imm = imm;
      while (!cmd_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("cmd_accept_timeout", 32'(n), 32'(0));
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("idle_timeout", 32'(n), 32'(0));
   endtask

   task automatic do_read(input logic [2:0] a, input logic [2:0] b,
                          output logic [W-1:0] ra, output logic [W-1:0] rb);
      do_cmd(OP_READ, 3'd0, a, b, '0);
      tick();
      check("read_valid", 32'(rsp_valid), 32'(1));
      ra = rsp_a;
      rb = rsp_b;
      wait_idle();
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int n_acc;

      repeat (3) @(negedge clk);
      check("rst_rsp_a", 32'(rsp_a), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_rf_enable", 32'(rf_enable), 32'(0));
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      rst_n = 1'b1;
      chk_en = 1'b1;
      tick();

      // WRITE then READ, response two cycles after accept
      do_cmd(OP_WRITE, 3'd3, 3'd0, 3'd0, 16'hABCD);
      wait_idle();
      do_cmd(OP_READ, 3'd0, 3'd3, 3'd0, '0);
      check("rd_lat_cycle1", 32'(rsp_valid), 32'(0));
      tick();
      check("rd_lat_cycle2", 32'(rsp_valid), 32'(1));
      check("rd_a_abcd", 32'(rsp_a), 32'h0000ABCD);
      check("rd_b_zero", 32'(rsp_b), 32'h0);
      wait_idle();

      // Response stalled by rsp_ready low
      rsp_ready = 1'b0;
      do_cmd(OP_READ, 3'd0, 3'd3, 3'd0, '0);
      tick();
      for (int j = 0; j < 5; j++) begin
         check("stall_valid", 32'(rsp_valid), 32'(1));
         check("stall_a", 32'(rsp_a), 32'h0000ABCD);
         check("stall_ready", 32'(cmd_ready), 32'(0));
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("stall_release_idle", 32'(cmd_ready), 32'(1));

      // WRITE + MOVE uses exactly two write cycles
      n_acc = en_total;
      do_cmd(OP_WRITE, 3'd1, 3'd0, 3'd0, 16'h4444);
      wait_idle();
      do_cmd(OP_MOVE, 3'd6, 3'd1, 3'd0, '0);
      wait_idle();
      check("move_en_cycles", 32'(en_total - n_acc), 32'(2));
      do_read(3'd6, 3'd1, ra, rb);
      check("move_dst", 32'(ra), 32'h4444);
      check("move_src", 32'(rb), 32'h4444);

      // Full CLEAR sweep
      for (int i = 0; i < 8; i++) begin
         do_cmd(OP_WRITE, 3'(i), 3'd0, 3'd0, 16'(16'h1111 * i));
         wait_idle();
      end
      do_cmd(OP_CLEAR, 3'd0, 3'd0, 3'd0, '0);
      for (int i = 0; i < 8; i++) begin
         check("clr_en", 32'(rf_enable), 32'(1));
         check("clr_in", 32'(rf_in), 32'(i));
         tick();
      end
      check("clr_done", 32'(busy), 32'(0));
      for (int i = 0; i < 8; i += 2) begin
         do_read(3'(i), 3'(i + 1), ra, rb);
         check("clr_read_a", 32'(ra), 32'h0);
         check("clr_read_b", 32'(rb), 32'h0);
      end

      // Reset lands right after the edge that clears r3
      for (int i = 0; i < 8; i++) begin
         do_cmd(OP_WRITE, 3'(i), 3'd0, 3'd0, 16'(16'h1111 * i));
         wait_idle();
      end
      do_cmd(OP_CLEAR, 3'd0, 3'd0, 3'd0, '0);
      repeat (3) tick();
      check("clr_r3_cycle", 32'(rf_in), 32'(3));
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("rst_abort_en", 32'(rf_enable), 32'(0));
      check("rst_abort_busy", 32'(busy), 32'(0));
      cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_dst = 3'd5; cmd_imm = 16'hBEEF;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 8; i++)
         check("rst_partial_rf", 32'(rf_mem[i]), (i < 4) ? 32'h0 : 32'(16'(16'h1111 * i)));
      rst_n = 1'b1;
      check("rst_release_ready", 32'(cmd_ready), 32'(1));
      tick();
      cmd_valid = 1'b0;
      check("first_accept_en", 32'(rf_enable), 32'(1));
      check("first_accept_in", 32'(rf_in), 32'(5));
      tick();
      check("first_accept_rf", 32'(rf_mem[5]), 32'hBEEF);

      // cmd_valid held high with changing commands: accept every other cycle
      n_acc = 0;
      cmd_valid = 1'b1;
      cmd_op = OP_WRITE;
      for (int i = 0; i < 10; i++) begin
         cmd_dst = 3'($urandom_range(0, 7));
         cmd_imm = 16'($urandom);
         if (cmd_ready) n_acc++;
         tick();
      end
      cmd_valid = 1'b0;
      wait_idle();
      check("b2b_accepts", 32'(n_acc), 32'(5));

      // Randomized traffic against the model
      rand_rdy = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = ($urandom_range(0, 15) == 0) ? OP_CLEAR : 2'($urandom_range(0, 2));
         cmd_dst   = 3'($urandom_range(0, 7));
         cmd_src_a = 3'($urandom_range(0, 7));
         cmd_src_b = 3'($urandom_range(0, 7));
         cmd_imm   = 16'($urandom);
         tick();
      end
      cmd_valid = 1'b0;
      rand_rdy = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();
      tick();
      for (int i = 0; i < 8; i++) check("rf_final", 32'(rf_mem[i]), 32'(mem_m[i]));

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_sequencer.md
RF_SEQUENCER -- requirements
Module: rf_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, 16, register data width.
REQ-002 SHALL have parameter NREG, 8, register count; select width is 3 bits.
REQ-003 SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00 WRITE, 01 READ, 10 MOVE, 11 CLEAR
- cmd_dst  in  3  destination register
- cmd_src_a  in  3  source A register
- cmd_src_b  in  3  source B register
- cmd_imm  in  WIDTH  immediate for WRITE
- rsp_valid  out  1  READ result available
- rsp_ready  in  1  result consumed
- rsp_a  out  WIDTH  READ value of src_a
- rsp_b  out  WIDTH  READ value of src_b
- rf_in  out  3  register-file write select
- rf_enable  out  1  register-file write enable
- rf_sel_A  out  3  register-file read select A
- rf_sel_B  out  3  register-file read select B
- rf_d  out  WIDTH  register-file write data
- rf_out_A  in  WIDTH  register-file read data A (combinational)
- rf_out_B  in  WIDTH  register-file read data B (combinational)
- busy  out  1  high whenever state is not IDLE

Function
REQ-005 SHALL treat the attached register file as writing rf_d to rf_in on the clk edge where rf_enable=1, with combinational reads.
REQ-006 SHALL use states IDLE, WR, RD, RESP, MV_RD, MV_WR, CLR.
REQ-007 cmd_ready SHALL equal (state==IDLE); on accept, op/dst/src_a/src_b/imm are latched and cmd inputs are ignored until IDLE.
REQ-008 WRITE: IDLE->WR; WR drives rf_enable=1, rf_in=dst, rf_d=imm for exactly one cycle; WR->IDLE.
REQ-009 READ: IDLE->RD; RD drives rf_sel_A=src_a, rf_sel_B=src_b and captures rf_out_A/rf_out_B into rsp_a/rsp_b at the RD-ending edge; RD->RESP.
REQ-010 RESP: rsp_valid=1, rsp_a/rsp_b stable; RESP->IDLE on the edge where rsp_ready=1; rsp_ready already high on entry completes in one cycle.
REQ-011 MOVE: IDLE->MV_RD (rf_sel_A=src_a, capture rf_out_A into temp) -> MV_WR (rf_enable=1, rf_in=dst, rf_d=temp) -> IDLE; no response; dst==src_a is legal.
REQ-012 CLEAR: IDLE->CLR with 3-bit counter=0; each CLR cycle drives rf_enable=1, rf_in=counter, rf_d=0; after counter==7 (8 cycles), CLR->IDLE without counter wrap-around.
REQ-013 rf_enable SHALL be 0 in IDLE, RD, RESP and MV_RD; rf_in and rf_d SHALL be 0 whenever rf_enable=0.
REQ-014 rf_sel_A/rf_sel_B SHALL be 0 in IDLE, and equal the latched sources in all other states.
REQ-015 rsp_valid SHALL be 0 outside RESP; rsp_ready outside RESP is ignored.
REQ-016 Latency from accept to write edge: WRITE 1 cycle, MOVE 2, CLEAR 1..8; READ rsp_valid rises 2 cycles after accept.

Reset
REQ-017 rst_n low SHALL force IDLE immediately: rf_enable=0, rsp_valid=0, busy=0, rsp_a/rsp_b/temp/counter/latched fields 0.
REQ-018 Reset mid-operation SHALL abort it; a partially swept CLEAR leaves registers already written at 0 and no further writes occur.
REQ-019 No command SHALL be accepted while rst_n is low; first accept is possible on the first edge after release.

Structure
REQ-020 Shared package rf_seq_pkg SHALL hold the WIDTH/NREG defaults, the 2-bit opcode constants and the state encoding.
REQ-021 Implementation SHALL be a single module with no sub-module; the register file is instantiated only in the bench.

Verification
REQ-022 Bench SHALL pair rf_sequencer with the 8x16 register file and cover:
- WRITE dst=3 imm=16'hABCD, then READ src_a=3 src_b=0 -> rsp_a=16'hABCD, rsp_b=16'h0000, rsp_valid 2 cycles after accept.
- READ with rsp_ready low for 5 cycles -> rsp_valid and data held stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready=1.
- WRITE r1=16'h4444, MOVE src_a=1 dst=6, READ 6/1 -> both 16'h4444; rf_enable high exactly 2 cycles total.
- Write r0..r7 with 16'h1111*i, CLEAR -> rf_enable high 8 consecutive cycles with rf_in 0..7, then all reads return 0.
- Assert rst_n low on the 4th CLR cycle -> rf_enable drops immediately, r0..r3=0, r4..r7 keep prior values, cmd_ready=1 after release.
- cmd_valid held high with new commands while busy -> none accepted until IDLE; back-to-back WRITEs accept every 2 cycles.
